// File: rtl/tsmp_frame_output_buffer_pkg.sv
// Shared definitions for the TSMP frame output buffer: flit layout, type codes, FSM states.
package tsmp_frame_output_buffer_pkg;

  localparam int unsigned FlitW = 134;

  // Flit type lives in the top two bits of every flit.
  localparam logic [1:0] FlitHead = 2'b01;
  localparam logic [1:0] FlitMid  = 2'b11;
  localparam logic [1:0] FlitTail = 2'b10;

  typedef enum logic [1:0] {WIdle, WRecv, WDrop} w_state_e;
  typedef enum logic       {RIdle, RSend}        r_state_e;

  // 16-bit event counter that sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tsmp_frame_output_buffer_if.sv
// Flit stream interface: encapsulation-stage input and FEM-facing output.
interface tsmp_frame_output_buffer_if;
  import tsmp_frame_output_buffer_pkg::*;

  logic [FlitW-1:0] iv_data;
  logic             i_data_wr;
  logic             i_out_rdy;
  logic [FlitW-1:0] ov_data;
  logic             o_data_wr;

  modport master (
    output iv_data, i_data_wr, i_out_rdy,
    input  ov_data, o_data_wr
  );

  modport slave (
    input  iv_data, i_data_wr, i_out_rdy,
    output ov_data, o_data_wr
  );
endinterface

// File: rtl/tsmp_buffer_ram.sv
// Simple dual-port flit RAM: one write port, one registered read port.
module tsmp_buffer_ram
  import tsmp_frame_output_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [FlitW-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  input  logic [DEPTH_LOG2-1:0] i_rd_addr,
  output logic [FlitW-1:0]      o_rd_data
);

  logic [FlitW-1:0] mem_q [2**DEPTH_LOG2];
  logic [FlitW-1:0] rd_data_q;

  // Storage array, no reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[i_wr_addr] <= i_wr_data;
  end

  // Read register doubles as the output flit register, so it holds when idle and clears on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_data_q <= '0;
    end else if (i_rd_en) begin
      rd_data_q <= mem_q[i_rd_addr];
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/tsmp_frame_output_buffer.sv
// Store-and-forward frame buffer: frames become visible to FEM only once their tail is written.
module tsmp_frame_output_buffer
  import tsmp_frame_output_buffer_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned MAX_FLITS  = 9
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  tsmp_frame_output_buffer_if.slave    bus,
  output logic [15:0]                  ov_drop_cnt,
  output logic [15:0]                  ov_err_cnt
);

  localparam int unsigned AW        = DEPTH_LOG2;
  localparam logic [AW:0] DepthW    = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] MaxFlitsW = (AW+1)'(MAX_FLITS);
  localparam logic [AW:0] PtrOne    = (AW+1)'(1);

  w_state_e         w_state_q;
  r_state_e         r_state_q;
  logic [AW:0]      wptr_q, cptr_q, rptr_q, pkt_cnt_q, frame_cnt_q;
  logic [AW:0]      base_ptr, free_cnt, wptr_nxt;
  logic [1:0]       in_type;
  logic             in_head, in_mid, in_tail;
  logic             head_fits, ram_we, commit, recv_err, idle_err;
  logic             rd_start, rd_en, o_wr_q;
  logic             tail_q [2**AW];
  logic [FlitW-1:0] rd_data;

  assign in_type = bus.iv_data[FlitW-1 -: 2];

  // Write-side decode; a head inside an open frame rolls back to cptr before being judged.
  always_comb begin
    in_head   = bus.i_data_wr && (in_type == FlitHead);
    in_mid    = bus.i_data_wr && (in_type == FlitMid);
    in_tail   = bus.i_data_wr && (in_type == FlitTail);
    base_ptr  = ((w_state_q == WRecv) && in_head) ? cptr_q : wptr_q;
    free_cnt  = DepthW - (base_ptr - rptr_q);
    head_fits = (free_cnt >= MaxFlitsW);
    ram_we    = (in_head && head_fits) ||
                ((w_state_q == WRecv) && (in_mid || in_tail) && (frame_cnt_q != MaxFlitsW));
    commit    = (w_state_q == WRecv) && in_tail && (frame_cnt_q != MaxFlitsW);
    // Any non-accepted flit in WRecv (overflow, bad type) and any head there are malformed frames.
    recv_err  = bus.i_data_wr && (w_state_q == WRecv) && (in_head || !ram_we);
    idle_err  = bus.i_data_wr && (w_state_q == WIdle) && !in_head;
    wptr_nxt  = wptr_q;
    if (ram_we) begin
      wptr_nxt = base_ptr + PtrOne;
    end else if (recv_err) begin
      wptr_nxt = cptr_q;
    end
  end

  // Write FSM, write/commit pointers and event counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w_state_q   <= WIdle;
      wptr_q      <= '0;
      cptr_q      <= '0;
      frame_cnt_q <= '0;
      ov_drop_cnt <= '0;
      ov_err_cnt  <= '0;
    end else begin
      wptr_q <= wptr_nxt;
      if (commit) cptr_q <= wptr_nxt;
      if (recv_err || idle_err) ov_err_cnt <= sat_inc(ov_err_cnt);
      if (in_head) begin
        if (head_fits) begin
          w_state_q   <= WRecv;
          frame_cnt_q <= PtrOne;
        end else begin
          w_state_q   <= WDrop;
          ov_drop_cnt <= sat_inc(ov_drop_cnt);
        end
      end else if (bus.i_data_wr) begin
        unique case (w_state_q)
          WRecv: begin
            if (commit) begin
              w_state_q <= WIdle;
            end else if (ram_we) begin
              frame_cnt_q <= frame_cnt_q + PtrOne;
            end else begin
              w_state_q <= WDrop;
            end
          end
          WDrop:   if (in_tail) w_state_q <= WIdle;
          default: ;
        endcase
      end
    end
  end

  // Per-slot tail marker so the read FSM knows where a frame ends without waiting for RAM data.
  always_ff @(posedge i_clk) begin
    if (ram_we) tail_q[base_ptr[AW-1:0]] <= in_tail;
  end

  // Read-side decode.
  always_comb begin
    rd_start = (r_state_q == RIdle) && (pkt_cnt_q != '0) && bus.i_out_rdy;
    rd_en    = rd_start || ((r_state_q == RSend) && bus.i_out_rdy);
  end

  // Read FSM: streams one committed frame at a time, one flit per ready cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state_q <= RIdle;
      rptr_q    <= '0;
      o_wr_q    <= 1'b0;
    end else begin
      o_wr_q <= rd_en;
      if (rd_en) rptr_q <= rptr_q + PtrOne;
      unique case (r_state_q)
        RIdle:   if (rd_start) r_state_q <= RSend;
        RSend:   if (rd_en && tail_q[rptr_q[AW-1:0]]) r_state_q <= RIdle;
        default: r_state_q <= RIdle;
      endcase
    end
  end

  // Committed-frame count; commit and read-start in one cycle cancel out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pkt_cnt_q <= '0;
    end else if (commit && !rd_start) begin
      pkt_cnt_q <= pkt_cnt_q + PtrOne;
    end else if (!commit && rd_start) begin
      pkt_cnt_q <= pkt_cnt_q - PtrOne;
    end
  end

  tsmp_buffer_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_en  (ram_we),
    .i_wr_addr(base_ptr[AW-1:0]),
    .i_wr_data(bus.iv_data),
    .i_rd_en  (rd_en),
    .i_rd_addr(rptr_q[AW-1:0]),
    .o_rd_data(rd_data)
  );

  assign bus.ov_data   = rd_data;
  assign bus.o_data_wr = o_wr_q;

endmodule

// File: tb/tb_tsmp_frame_output_buffer.sv
// Directed bench for tsmp_frame_output_buffer: cycle vector table plus multi-cycle sequences.
module tb_tsmp_frame_output_buffer;
  import tsmp_frame_output_buffer_pkg::*;

  typedef struct {
    logic       wr;
    logic [1:0] ty;
    logic [3:0] inv;
    logic [7:0] tag;
    logic       rdy;
    logic       ewr;
    logic [1:0] ety;
    logic [3:0] einv;
    logic [7:0] etag;
    int         epkt;   // -1: not checked on this row
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] drop_cnt;
  logic [15:0] err_cnt;
  int          checks;
  int          errors;
  vec_t        tbl[$];
  logic [133:0] out_q[$];
  logic [133:0] exp_q[$];

  tsmp_frame_output_buffer_if bus ();

  tsmp_frame_output_buffer #(
    .DEPTH_LOG2(6),
    .MAX_FLITS (9)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .ov_drop_cnt(drop_cnt),
    .ov_err_cnt (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  // Every emitted flit, in order.
  always @(negedge clk) begin
    if (bus.o_data_wr === 1'b1) out_q.push_back(bus.ov_data);
  end

  function automatic logic [133:0] mk(input logic [1:0] ty, input logic [3:0] inv,
                                      input logic [7:0] tag);
    return {ty, inv, {16{tag}}};
  endfunction

  function automatic vec_t v(input logic wr, input logic [1:0] ty, input logic [3:0] inv,
                             input logic [7:0] tag, input logic rdy, input logic ewr,
                             input logic [1:0] ety, input logic [3:0] einv,
                             input logic [7:0] etag, input int epkt);
    vec_t r;
    r = '{wr, ty, inv, tag, rdy, ewr, ety, einv, etag, epkt};
    return r;
  endfunction

  task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic put(input logic [1:0] ty, input logic [3:0] inv, input logic [7:0] tag);
    @(negedge clk);
    bus.i_data_wr = 1'b1;
    bus.iv_data   = mk(ty, inv, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_data_wr = 1'b0;
      bus.iv_data   = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.i_data_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_counters(input string name, input int edrop, input int eerr);
    check({name, " drop_cnt"}, 134'(drop_cnt), 134'(edrop));
    check({name, " err_cnt"}, 134'(err_cnt), 134'(eerr));
  endtask

  task automatic check_stream(input string name);
    check({name, " count"}, 134'(out_q.size()), 134'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      check($sformatf("%s flit%0d", name, i), out_q[i], exp_q[i]);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.i_data_wr = 1'b0;
    bus.iv_data   = '0;
    bus.i_out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset o_data_wr", 134'(bus.o_data_wr), 134'(0));
    check("reset ov_data", bus.ov_data, 134'(0));
    check("reset pkt_cnt", 134'(dut.pkt_cnt_q), 134'(0));
    check_counters("reset", 0, 0);

    // 3-flit frame, first flit out 2 cycles after the tail.
    tbl.push_back(v(1, FlitHead, 0, 8'h11, 1, 0, 2'b00, 0, 8'h00, -1));
    tbl.push_back(v(1, FlitMid,  0, 8'h12, 1, 0, 2'b00, 0, 8'h00, -1));
    tbl.push_back(v(1, FlitTail, 5, 8'h13, 1, 0, 2'b00, 0, 8'h00, -1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 1, 0, 2'b00, 0, 8'h00, 1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 1, 1, FlitHead, 0, 8'h11, 0));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 1, 1, FlitMid,  0, 8'h12, -1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 1, 1, FlitTail, 5, 8'h13, -1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 1, 0, FlitTail, 5, 8'h13, 0));
    // Frame B stored with rdy low, frame C's tail lands on B's read-start, then rdy toggles.
    tbl.push_back(v(1, FlitHead, 0, 8'h21, 0, 0, FlitTail, 5, 8'h13, -1));
    tbl.push_back(v(1, FlitMid,  0, 8'h22, 0, 0, FlitTail, 5, 8'h13, -1));
    tbl.push_back(v(1, FlitMid,  0, 8'h23, 0, 0, FlitTail, 5, 8'h13, -1));
    tbl.push_back(v(1, FlitTail, 0, 8'h24, 0, 0, FlitTail, 5, 8'h13, -1));
    tbl.push_back(v(1, FlitHead, 0, 8'h31, 0, 0, FlitTail, 5, 8'h13, 1));
    tbl.push_back(v(1, FlitMid,  0, 8'h32, 0, 0, FlitTail, 5, 8'h13, 1));
    tbl.push_back(v(1, FlitTail, 2, 8'h33, 1, 0, FlitTail, 5, 8'h13, 1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 0, 1, FlitHead, 0, 8'h21, 1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 1, 0, FlitHead, 0, 8'h21, -1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 0, 1, FlitMid,  0, 8'h22, -1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 1, 0, FlitMid,  0, 8'h22, -1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 0, 1, FlitMid,  0, 8'h23, -1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 1, 0, FlitMid,  0, 8'h23, -1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 0, 1, FlitTail, 0, 8'h24, -1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 1, 0, FlitTail, 0, 8'h24, 1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 1, 1, FlitHead, 0, 8'h31, 0));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 1, 1, FlitMid,  0, 8'h32, -1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 1, 1, FlitTail, 2, 8'h33, -1));
    tbl.push_back(v(0, 2'b00,    0, 8'h00, 1, 0, FlitTail, 2, 8'h33, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      check($sformatf("vec%0d o_data_wr", i), 134'(bus.o_data_wr), 134'(tbl[i].ewr));
      check($sformatf("vec%0d ov_data", i), bus.ov_data,
            mk(tbl[i].ety, tbl[i].einv, tbl[i].etag));
      if (tbl[i].epkt >= 0) begin
        check($sformatf("vec%0d pkt_cnt", i), 134'(dut.pkt_cnt_q), 134'(tbl[i].epkt));
      end
      bus.i_data_wr = tbl[i].wr;
      bus.iv_data   = mk(tbl[i].ty, tbl[i].inv, tbl[i].tag);
      bus.i_out_rdy = tbl[i].rdy;
    end
    idle(2);
    check_counters("table", 0, 0);

    // Fill: 7 frames of 9 flits with rdy low, 8th head dropped, then drain.
    do_reset();
    check_counters("after reset", 0, 0);
    bus.i_out_rdy = 1'b0;
    out_q.delete();
    exp_q.delete();
    for (int f = 1; f <= 7; f++) begin
      put(FlitHead, 0, 8'(f * 16));
      exp_q.push_back(mk(FlitHead, 0, 8'(f * 16)));
      for (int k = 1; k <= 7; k++) begin
        put(FlitMid, 0, 8'(f * 16 + k));
        exp_q.push_back(mk(FlitMid, 0, 8'(f * 16 + k)));
      end
      put(FlitTail, 4'(f), 8'(f * 16 + 8));
      exp_q.push_back(mk(FlitTail, 4'(f), 8'(f * 16 + 8)));
      if (f == 6) begin
        idle(1);
        #1;
        check("free after 6 frames", 134'(dut.free_cnt), 134'(10));
      end
    end
    idle(1);
    #1;
    check("free after 7 frames", 134'(dut.free_cnt), 134'(1));
    put(FlitHead, 0, 8'h80);
    put(FlitTail, 0, 8'h88);
    idle(2);
    check_counters("fill", 1, 0);
    check("fill nothing out while rdy low", 134'(out_q.size()), 134'(0));
    bus.i_out_rdy = 1'b1;
    idle(100);
    check_stream("fill");

    // Missing tail: first frame vanishes, second passes.
    do_reset();
    check_counters("after reset 2", 0, 0);
    out_q.delete();
    exp_q.delete();
    put(FlitHead, 0, 8'h41);
    put(FlitMid,  0, 8'h42);
    put(FlitHead, 0, 8'h51);
    put(FlitMid,  0, 8'h52);
    put(FlitTail, 7, 8'h53);
    idle(12);
    exp_q.push_back(mk(FlitHead, 0, 8'h51));
    exp_q.push_back(mk(FlitMid,  0, 8'h52));
    exp_q.push_back(mk(FlitTail, 7, 8'h53));
    check_stream("no tail");
    check_counters("no tail", 0, 1);

    // Oversize frame: head + 9 mids overflows, dropped to tail; next frame passes.
    do_reset();
    out_q.delete();
    exp_q.delete();
    put(FlitHead, 0, 8'h61);
    for (int k = 0; k < 9; k++) put(FlitMid, 0, 8'(8'h62 + k));
    put(FlitTail, 0, 8'h6f);
    idle(10);
    check("oversize nothing out", 134'(out_q.size()), 134'(0));
    check_counters("oversize", 0, 1);
    put(FlitHead, 0, 8'h71);
    put(FlitTail, 1, 8'h72);
    idle(8);
    exp_q.push_back(mk(FlitHead, 0, 8'h71));
    exp_q.push_back(mk(FlitTail, 1, 8'h72));
    check_stream("after oversize");

    // Reset mid-frame with two frames stored and err_cnt nonzero.
    bus.i_out_rdy = 1'b0;
    out_q.delete();
    exp_q.delete();
    put(FlitHead, 0, 8'h81);
    put(FlitMid,  0, 8'h82);
    put(FlitTail, 0, 8'h83);
    put(FlitHead, 0, 8'h91);
    put(FlitTail, 0, 8'h92);
    put(FlitHead, 0, 8'ha1);
    put(FlitMid,  0, 8'ha2);
    @(negedge clk);
    rst           = 1'b1;
    bus.i_data_wr = 1'b0;
    @(negedge clk);
    check("midreset o_data_wr", 134'(bus.o_data_wr), 134'(0));
    check("midreset ov_data", bus.ov_data, 134'(0));
    check("midreset pkt_cnt", 134'(dut.pkt_cnt_q), 134'(0));
    check_counters("midreset", 0, 0);
    rst           = 1'b0;
    bus.i_out_rdy = 1'b1;
    bus.i_data_wr = 1'b1;
    bus.iv_data   = mk(FlitHead, 0, 8'hb1);
    put(FlitMid,  0, 8'hb2);
    put(FlitTail, 3, 8'hb3);
    idle(20);
    exp_q.push_back(mk(FlitHead, 0, 8'hb1));
    exp_q.push_back(mk(FlitMid,  0, 8'hb2));
    exp_q.push_back(mk(FlitTail, 3, 8'hb3));
    check_stream("post reset");
    check_counters("post reset", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tsmp_frame_output_buffer.md
TSMP_FRAME_OUTPUT_BUFFER -- requirements
Module: tsmp_frame_output_buffer

Interface
REQ-001 Parameter DEPTH_LOG2, default 6, log2 of the flit RAM depth (64 flits).
REQ-002 Parameter MAX_FLITS, default 9, maximum flits per frame: 1 metadata flit plus 128 B.
REQ-003 Clocking is fixed: one clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  sole clock.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 iv_data  input  134  flit from encapsulation stage; [133:132] 01=head, 11=middle, 10=tail; [131:128] invalid byte count on tail.
REQ-007 i_data_wr  input  1  iv_data valid this cycle.
REQ-008 i_out_rdy  input  1  downstream (FEM) can accept a flit in the next cycle.
REQ-009 ov_data  output  134  flit to FEM.
REQ-010 o_data_wr  output  1  ov_data valid.
REQ-011 ov_drop_cnt  output  16  frames dropped for lack of space, saturating.
REQ-012 ov_err_cnt  output  16  malformed frames discarded, saturating.

Function
REQ-013 The block shall store frames whole and forward only committed (tail-received) frames, so FEM never sees a partial frame.
REQ-014 Write FSM states: W_IDLE, W_RECV, W_DROP.
REQ-015 W_IDLE, head with free >= MAX_FLITS: write the flit and go to W_RECV.
REQ-016 W_IDLE, head with free < MAX_FLITS: write nothing, ov_drop_cnt+1, go to W_DROP.
REQ-017 Free space: free = 2^DEPTH_LOG2 - (wptr - rptr), using pointers of DEPTH_LOG2+1 bits with natural wrap-around.
REQ-018 W_IDLE, middle or tail flit: ignore it, ov_err_cnt+1.
REQ-019 W_RECV, middle: write the flit.
REQ-020 W_RECV, tail: write the flit, set committed pointer cptr = wptr+1, increment pkt_cnt, go to W_IDLE.
REQ-021 W_RECV, head (tail missing): set wptr = cptr (rollback), ov_err_cnt+1, then process the new head exactly as in W_IDLE in the same cycle.
REQ-022 W_RECV, flit count would exceed MAX_FLITS: rollback wptr = cptr, ov_err_cnt+1, go to W_DROP.
REQ-023 W_DROP: discard all flits; on tail return to W_IDLE; on head handle it as in W_IDLE.
REQ-024 i_data_wr=0 in any write state: hold state; idle gaps inside a frame are legal.
REQ-025 Read FSM states: R_IDLE, R_SEND.
REQ-026 R_IDLE with pkt_cnt>0 and i_out_rdy=1: read the head flit, decrement pkt_cnt, go to R_SEND.
REQ-027 R_SEND: read one flit per cycle in which i_out_rdy=1; after reading the tail, go to R_IDLE.
REQ-028 A flit read in cycle N shall appear on ov_data with o_data_wr=1 in cycle N+1 (registered, 1-cycle latency); o_data_wr=0 otherwise.
REQ-029 ov_data shall hold its last value when o_data_wr=0.
REQ-030 A commit and a read-start in the same cycle leave pkt_cnt unchanged; pkt_cnt width is DEPTH_LOG2+1.
REQ-031 Minimum latency, tail written to head out, shall be 2 cycles with i_out_rdy=1.
REQ-032 Flit contents shall be forwarded unmodified; the head type 01 is preserved.
REQ-033 Counters shall saturate at 16'hFFFF.

Reset
REQ-034 On i_rst=1 at a clock edge: wptr, cptr, rptr, pkt_cnt, ov_drop_cnt, ov_err_cnt = 0; ov_data = 134'b0; o_data_wr = 0; FSMs to W_IDLE/R_IDLE.
REQ-035 Reset mid-frame shall discard all buffered data; RAM contents need no reset.
REQ-036 The first flit accepted after reset is a head arriving in the cycle after i_rst falls.

Structure
REQ-037 A shared header holds the flit type codes (HEAD=2'b01, MID=2'b11, TAIL=2'b10), the 134-bit flit width, and the FSM state encodings.
REQ-038 One sub-module, tsmp_buffer_ram: simple dual-port RAM, 134 x 2^DEPTH_LOG2, one write port, one registered read port.
REQ-039 The write FSM, read FSM, pointers and counters live in the top module.

Verification
REQ-040 The bench shall cover the following scenarios, with rdy=1 unless stated.
- 3-flit frame (head, mid, tail with [131:128]=4'h5): identical 3 flits out contiguously, first flit 2 cycles after tail in; counters 0.
- i_out_rdy=0 while 7 frames of 9 flits (63 flits) arrive: frames 1-6 stored (54 flits, free=10), frame 7 stored (free=1); an 8th head gives ov_drop_cnt=1; raising rdy outputs 63 flits in order.
- Head, mid, then new head without tail: first frame never appears, ov_err_cnt=1, second frame output intact.
- Head followed by 9 middles: ov_err_cnt=1, rest dropped until tail, nothing output; next frame passes.
- i_out_rdy toggled 1,0,1,0 during a 4-flit frame: o_data_wr pulses exactly the cycle after each rdy=1 cycle, order preserved; tail written the same cycle a head is read gives pkt_cnt unchanged.
- Assert i_rst for 1 cycle mid-frame with 2 frames stored: outputs 0, nothing from old frames ever emitted, counters 0.
